mod_tick_counter: RTL and testbench

//   Free-running modulo-N up-counter with a one-cycle terminal-count strobe.

---
 rtl/r1_pkg.sv | 18 +
 rtl/r1_prescaler.sv | 30 +++
 rtl/mod_tick_counter.sv | 53 +++++
 tb/tb_mod_tick_counter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/r1_pkg.sv
// rtl/r1_pkg.sv - shared defaults and width helper for the r1 tick counter
package r1_pkg;

  localparam int R1_WIDTH    = 4;
  localparam int R1_MODULUS  = 16;
  localparam int R1_PRESCALE = 4;

  // Smallest w with 2**w >= value; returns 0 for value <= 1.
  function automatic int r1_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/r1_prescaler.sv
// rtl/r1_prescaler.sv - divides clk by PRESCALE into a one-clock step_en pulse
module r1_prescaler
  import r1_pkg::*;
#(
  parameter int PRESCALE = R1_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  output logic step_en
);

  // PRESCALE=1 yields a zero-width counter, so keep at least one bit.
  localparam int CW = (r1_clog2(PRESCALE) < 1) ? 1 : r1_clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt >= LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign step_en = (cnt == LAST);

endmodule

// File: rtl/mod_tick_counter.sv
// rtl/mod_tick_counter.sv - modulo-MODULUS up-counter with terminal-count tick
// Optional prescaler enabled by defining R1_PRESCALE_EN.
module mod_tick_counter
  import r1_pkg::*;
#(
  parameter int WIDTH    = R1_WIDTH,
  parameter int MODULUS  = R1_MODULUS,
  parameter int PRESCALE = R1_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out,
  output logic             tick
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH) || PRESCALE < 1) begin : g_bad_params
      $error("mod_tick_counter: illegal MODULUS/WIDTH/PRESCALE combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic step_en;

`ifdef R1_PRESCALE_EN
  r1_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .step_en(step_en)
  );
`else
  assign step_en = 1'b1;
`endif

  // >= rather than == so an out-of-range state still wraps back to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (step_en) begin
      if (out >= LAST) begin
        out <= '0;
      end else begin
        out <= out + 1'b1;
      end
    end
  end

  assign tick = step_en & (out == LAST);

endmodule

// File: tb/tb_mod_tick_counter.sv
// tb/tb_mod_tick_counter.sv - randomized self-checking bench for mod_tick_counter
module tb_mod_tick_counter;
  import r1_pkg::*;

`ifdef R1_PRESCALE_EN
  localparam int P = R1_PRESCALE;
`else
  localparam int P = 1;
`endif
  localparam int MA = 16;
  localparam int MB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] out_a, out_b;
  logic       tick_a, tick_b;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;   // edges since reset was last sampled high
  bit valid   = 1'b0;

  mod_tick_counter #(.WIDTH(4), .MODULUS(MA)) u_dut_a (
    .clk(clk), .reset(reset), .out(out_a), .tick(tick_a)
  );

  mod_tick_counter #(.WIDTH(4), .MODULUS(MB)) u_dut_b (
    .clk(clk), .reset(reset), .out(out_b), .tick(tick_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic int exp_out(input int m);
    return (t / P) % m;
  endfunction

  function automatic int exp_tick(input int m);
    return ((t % P) == (P - 1) && exp_out(m) == m - 1) ? 1 : 0;
  endfunction

  // One clock: apply reset, advance the model on the edge, compare on the falling edge.
  task automatic cyc(input logic r);
    reset = r;
    @(posedge clk);
    if (r) begin
      t = 0;
      valid = 1'b1;
    end else begin
      t = t + 1;
    end
    @(negedge clk);
    if (valid) begin
      check("out_a", 32'(out_a), 32'(exp_out(MA)));
      check("tick_a", 32'(tick_a), 32'(exp_tick(MA)));
      check("out_b", 32'(out_b), 32'(exp_out(MB)));
      check("tick_b", 32'(tick_b), 32'(exp_tick(MB)));
    end
  endtask

  initial begin
    bit found;

    // Reset hold
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      check("reset_out", 32'(out_a), 32'd0);
      check("reset_tick", 32'(tick_a), 32'd0);
    end

    // Free run with literal pins on wrap points
    for (int k = 1; k <= 36 * P; k++) begin
      cyc(1'b0);
      if (k == 16 * P - 1) begin
        check("lit_a_last", 32'(out_a), 32'd15);
        check("lit_a_tick", 32'(tick_a), 32'd1);
      end
      if (k == 16 * P) begin
        check("lit_a_wrap", 32'(out_a), 32'd0);
        check("lit_a_notick", 32'(tick_a), 32'd0);
      end
      if (k == 10 * P - 1) begin
        check("lit_b_last", 32'(out_b), 32'd9);
        check("lit_b_tick", 32'(tick_b), 32'd1);
      end
      if (k == 20 * P) check("lit_b_wrap2", 32'(out_b), 32'd0);
      if (k == 20 * P - 1) check("lit_b_tick2", 32'(tick_b), 32'd1);
    end

    // Mid-count reset at out=7
    found = 1'b0;
    for (int i = 0; i < 40 * P && !found; i++) begin
      if (out_a == 4'd7) found = 1'b1;
      else cyc(1'b0);
    end
    check("find_out7", 32'(found), 32'd1);
    cyc(1'b1);
    check("mid_reset_out", 32'(out_a), 32'd0);
    check("mid_reset_tick", 32'(tick_a), 32'd0);
    for (int i = 0; i < 3 * P; i++) cyc(1'b0);
    check("mid_resume", 32'(out_a), 32'd3);

    // Reset toggle
    cyc(1'b1);
    cyc(1'b0);
    check("toggle_max1", 32'(out_a <= 4'd1), 32'd1);
    cyc(1'b1);
    check("toggle_held", 32'(out_a), 32'd0);
    cyc(1'b1);
    check("toggle_held2", 32'(out_a), 32'd0);

    // Randomized run with sporadic resets
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
